pipe_ctrl_unit: RTL and testbench

- Successor to the combinational MIPS main control: it decodes opcode/funct in ID, resolves branch/jump, and registers the ID/EX control bundle.
- Adds load-use hazard detection with bubble insertion and IF/ID flush on taken control transfers.
- Adds a parametrised multi-cycle mult/div sequencer that stalls dependent instructions.
- Sits between the IF/ID register and the ID/EX register of the 5-stage core.

---
 rtl/pipe_ctrl_unit.sv | 194 +++++++++++++++++++
 tb/tb_pipe_ctrl_unit.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl_unit.sv
// ID-stage control for the 5-stage core: decode, branch/jump resolution,
// load-use and mult/div hazard stalls, ID/EX control register, MD sequencer.
module pipe_ctrl_unit #(
  parameter int unsigned MULT_LAT = 4,
  parameter int unsigned DIV_LAT  = 16,
  parameter int unsigned CNT_W    = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  inst,
  input  logic [5:0]  funct,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        eq,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        if_flush,
  output logic        pc_src,
  output logic        jump,
  output logic        jump_r,
  output logic [10:0] ex_ctrl,
  output logic        md_start,
  output logic        md_op,
  output logic        md_busy,
  output logic        md_done
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] F_SLL  = 6'd0;
  localparam logic [5:0] F_JR   = 6'd8;
  localparam logic [5:0] F_JALR = 6'd9;
  localparam logic [5:0] F_MFHI = 6'd16;
  localparam logic [5:0] F_MFLO = 6'd18;
  localparam logic [5:0] F_MULT = 6'd24;
  localparam logic [5:0] F_DIV  = 6'd26;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_LAT);
  localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef struct packed {
    logic       shift;
    logic       ra_write;
    logic       mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic       reg_dst;
    logic [1:0] alu_op;
    logic       alu_src;
    logic       reg_write;
    logic       branch;
  } ctrl_t;

  ctrl_t            bundle, ex_q;
  logic [4:0]       ex_rt;
  logic             jump_d, jump_r_d, br_taken, lu_stall, md_stall, stall;
  logic             is_rtype, is_md_op, uses_md, issue;
  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             md_start_d, md_op_d;

  // Main decode of the ID instruction into the EX control bundle
  always_comb begin
    bundle   = '0;
    jump_d   = 1'b0;
    jump_r_d = 1'b0;
    case (inst)
      OP_RTYPE: begin
        bundle.reg_write = 1'b1;
        bundle.reg_dst   = 1'b1;
        bundle.alu_op    = 2'b10;
        case (funct)
          F_SLL:   bundle.shift = 1'b1;
          F_JR: begin
            bundle.reg_write = 1'b0;
            jump_r_d         = 1'b1;
          end
          F_JALR: begin
            bundle.ra_write = 1'b1;
            jump_r_d        = 1'b1;
          end
          default: ;
        endcase
      end
      OP_BEQ, OP_BNE: begin
        bundle.branch = 1'b1;
        bundle.alu_op = 2'b01;
      end
      OP_J:   jump_d = 1'b1;
      OP_JAL: begin
        jump_d           = 1'b1;
        bundle.reg_write = 1'b1;
        bundle.ra_write  = 1'b1;
      end
      OP_LW: begin
        bundle.alu_src    = 1'b1;
        bundle.mem_read   = 1'b1;
        bundle.mem_to_reg = 1'b1;
        bundle.reg_write  = 1'b1;
      end
      OP_SW: begin
        bundle.alu_src   = 1'b1;
        bundle.mem_write = 1'b1;
      end
      default: begin
        bundle.alu_src   = 1'b1;
        bundle.reg_write = 1'b1;
        bundle.alu_op    = 2'b11;
      end
    endcase
  end

  assign is_rtype = (inst == OP_RTYPE);
  assign is_md_op = is_rtype && (funct == F_MULT || funct == F_DIV);
  assign uses_md  = is_md_op || (is_rtype && (funct == F_MFHI || funct == F_MFLO));
  assign br_taken = (inst == OP_BEQ && eq) || (inst == OP_BNE && !eq);

  assign md_busy = (state_q == S_BUSY);
  assign md_done = md_busy && (cnt_q == CNT_ONE);

  assign lu_stall = ex_q.mem_read && (ex_rt != 5'd0) && (ex_rt == id_rs || ex_rt == id_rt);
  assign md_stall = uses_md && md_busy;
  assign stall    = lu_stall || md_stall;
  assign issue    = is_md_op && !stall;

  // A stalled instruction must not redirect fetch; it resolves once released
  assign pc_write   = !stall;
  assign ifid_write = !stall;
  assign pc_src     = br_taken && !stall;
  assign jump       = jump_d && !stall;
  assign jump_r     = jump_r_d && !stall;
  assign if_flush   = (br_taken || jump_d || jump_r_d) && !stall;

  assign ex_ctrl = ex_q;

  // ID/EX control register; a stall injects an all-zero bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q  <= '0;
      ex_rt <= 5'd0;
    end else begin
      ex_q  <= stall ? ctrl_t'(11'd0) : bundle;
      ex_rt <= id_rt;
    end
  end

  // MD sequencer next-state logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    md_start_d = 1'b0;
    md_op_d    = md_op;
    case (state_q)
      S_IDLE: begin
        if (issue) begin
          md_start_d = 1'b1;
          md_op_d    = (funct == F_DIV);
          cnt_d      = (funct == F_DIV) ? DIV_CNT : MULT_CNT;
          state_d    = S_BUSY;
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      md_start <= 1'b0;
      md_op    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      md_start <= md_start_d;
      md_op    <= md_op_d;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Bench for pipe_ctrl_unit: directed hazard/MD/reset scenarios plus random
// instruction streams, all compared to a behavioural model of the ID stage.
module tb_pipe_ctrl_unit;

  localparam int unsigned MULT_LAT = 4;
  localparam int unsigned DIV_LAT  = 16;
  localparam int unsigned CNT_W    = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  inst, funct;
  logic [4:0]  id_rs, id_rt;
  logic        eq;
  logic        pc_write, ifid_write, if_flush, pc_src, jump, jump_r;
  logic [10:0] ex_ctrl;
  logic        md_start, md_op, md_busy, md_done;

  pipe_ctrl_unit #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .inst(inst), .funct(funct), .id_rs(id_rs), .id_rt(id_rt),
    .eq(eq), .pc_write(pc_write), .ifid_write(ifid_write), .if_flush(if_flush),
    .pc_src(pc_src), .jump(jump), .jump_r(jump_r), .ex_ctrl(ex_ctrl),
    .md_start(md_start), .md_op(md_op), .md_busy(md_busy), .md_done(md_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int busy_seen, start_seen, stall_seen;

  // Model state: what sits in ID/EX and how many MD cycles remain
  logic [10:0] m_ex;
  logic [4:0]  m_rt;
  logic        m_start, m_op;
  int          m_left;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ex = '0; m_rt = '0; m_start = 1'b0; m_op = 1'b0; m_left = 0;
  endtask

  function automatic logic [10:0] ref_bundle(input logic [5:0] op, input logic [5:0] fn);
    logic sh, ra, m2r, mr, mw, rd, asrc, rw, br;
    logic [1:0] aop;
    {sh, ra, m2r, mr, mw, rd, asrc, rw, br} = '0;
    aop = 2'b00;
    if (op == 6'h00) begin
      rw = 1; rd = 1; aop = 2'b10;
      if (fn == 6'd0) sh = 1;
      if (fn == 6'd8) rw = 0;
      if (fn == 6'd9) ra = 1;
    end else if (op == 6'h04 || op == 6'h05) begin
      br = 1; aop = 2'b01;
    end else if (op == 6'h02) begin
    end else if (op == 6'h03) begin
      rw = 1; ra = 1;
    end else if (op == 6'h23) begin
      asrc = 1; mr = 1; m2r = 1; rw = 1;
    end else if (op == 6'h2b) begin
      asrc = 1; mw = 1;
    end else begin
      asrc = 1; rw = 1; aop = 2'b11;
    end
    return {sh, ra, m2r, mr, mw, rd, aop, asrc, rw, br};
  endfunction

  // One ID cycle: drive at negedge, compare shortly after, advance model at posedge
  task automatic run_cycle(input logic [5:0] op, input logic [5:0] fn,
                           input logic [4:0] rs, input logic [4:0] rt, input logic e);
    logic [10:0] bnd;
    logic lu, mds, stl, brt, jmp, jmpr, iss;
    @(negedge clk);
    inst = op; funct = fn; id_rs = rs; id_rt = rt; eq = e;
    #2;
    bnd  = ref_bundle(op, fn);
    lu   = m_ex[7] && (m_rt != 0) && (m_rt == rs || m_rt == rt);
    mds  = (op == 0) && (fn == 24 || fn == 26 || fn == 16 || fn == 18) && (m_left > 0);
    stl  = lu || mds;
    brt  = (op == 6'h04 && e) || (op == 6'h05 && !e);
    jmp  = (op == 6'h02 || op == 6'h03);
    jmpr = (op == 0) && (fn == 8 || fn == 9);
    iss  = (op == 0) && (fn == 24 || fn == 26) && !stl;
    check("pc_write",   pc_write,   !stl);
    check("ifid_write", ifid_write, !stl);
    check("pc_src",     pc_src,     brt && !stl);
    check("jump",       jump,       jmp && !stl);
    check("jump_r",     jump_r,     jmpr && !stl);
    check("if_flush",   if_flush,   (brt || jmp || jmpr) && !stl);
    check("ex_ctrl",    ex_ctrl,    m_ex);
    check("md_start",   md_start,   m_start);
    check("md_op",      md_op,      m_op);
    check("md_busy",    md_busy,    m_left > 0);
    check("md_done",    md_done,    m_left == 1);
    if (md_busy) busy_seen++;
    if (md_start) start_seen++;
    if (!pc_write) stall_seen++;
    @(posedge clk);
    m_ex    = stl ? 11'd0 : bnd;
    m_rt    = rt;
    m_start = iss;
    if (iss) begin
      m_op   = (fn == 26);
      m_left = (fn == 26) ? DIV_LAT : MULT_LAT;
    end else if (m_left > 0) begin
      m_left--;
    end
  endtask

  task automatic run_random();
    logic [5:0] op, fn;
    op = 6'h00; fn = 6'h20;
    case ($urandom_range(0, 14))
      0:  fn = 6'd0;
      1:  fn = 6'd8;
      2:  fn = 6'd9;
      3:  fn = 6'd24;
      4:  fn = 6'd26;
      5:  fn = 6'd16;
      6:  fn = 6'd18;
      7:  op = 6'h02;
      8:  op = 6'h03;
      9:  op = 6'h04;
      10: op = 6'h05;
      11: op = 6'h23;
      12: op = 6'h2b;
      13: op = 6'($urandom);
      default: fn = 6'($urandom);
    endcase
    run_cycle(op, fn, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 1'($urandom));
  endtask

  initial begin
    rst = 1'b1; inst = 6'h23; funct = 6'h00; id_rs = 5'd1; id_rt = 5'd2; eq = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check("reset_ex_ctrl", ex_ctrl, 11'd0);
    check("reset_md_busy", md_busy, 1'b0);
    check("reset_md_start", md_start, 1'b0);
    @(posedge clk); #1 rst = 1'b0;
    run_cycle(6'h23, 6'h00, 5'd1, 5'd2, 1'b0);
    #1 check("lw_first_edge", ex_ctrl, 11'b00110000110);

    // Load-use with a dependent add, then with rs = $0 and unrelated regs
    run_cycle(6'h23, 6'h00, 5'd1, 5'd5, 1'b0);
    run_cycle(6'h00, 6'h20, 5'd5, 5'd6, 1'b0);
    run_cycle(6'h23, 6'h00, 5'd1, 5'd0, 1'b0);
    run_cycle(6'h00, 6'h20, 5'd0, 5'd0, 1'b0);
    run_cycle(6'h23, 6'h00, 5'd1, 5'd5, 1'b0);
    run_cycle(6'h00, 6'h20, 5'd3, 5'd4, 1'b0);

    // Branches, jal, and a load-use stall colliding with a taken beq
    run_cycle(6'h04, 6'h00, 5'd1, 5'd2, 1'b1);
    run_cycle(6'h04, 6'h00, 5'd1, 5'd2, 1'b0);
    run_cycle(6'h05, 6'h00, 5'd1, 5'd2, 1'b0);
    run_cycle(6'h05, 6'h00, 5'd1, 5'd2, 1'b1);
    run_cycle(6'h03, 6'h00, 5'd1, 5'd2, 1'b0);
    #1 check("jal_ra_write", ex_ctrl[9], 1'b1);
    run_cycle(6'h23, 6'h00, 5'd1, 5'd7, 1'b0);
    run_cycle(6'h04, 6'h00, 5'd7, 5'd2, 1'b1);
    run_cycle(6'h04, 6'h00, 5'd7, 5'd2, 1'b1);

    // div occupancy with independent adds behind it
    busy_seen = 0; start_seen = 0;
    run_cycle(6'h00, 6'd26, 5'd1, 5'd2, 1'b0);
    repeat (20) run_cycle(6'h00, 6'h20, 5'd1, 5'd2, 1'b0);
    check("div_busy_cycles", busy_seen, DIV_LAT);
    check("div_start_pulses", start_seen, 1);

    // mflo waits out the whole div
    stall_seen = 0;
    run_cycle(6'h00, 6'd26, 5'd1, 5'd2, 1'b0);
    repeat (20) run_cycle(6'h00, 6'd18, 5'd0, 5'd0, 1'b0);
    check("mflo_stall_cycles", stall_seen, DIV_LAT);

    // Reset in the 3rd busy cycle of a mult, then a fresh mult
    run_cycle(6'h00, 6'd24, 5'd1, 5'd2, 1'b0);
    run_cycle(6'h00, 6'h20, 5'd1, 5'd2, 1'b0);
    run_cycle(6'h00, 6'h20, 5'd1, 5'd2, 1'b0);
    @(negedge clk); #2;
    check("pre_reset_busy", md_busy, 1'b1);
    rst = 1'b1; #1;
    check("midop_md_busy", md_busy, 1'b0);
    check("midop_md_done", md_done, 1'b0);
    check("midop_ex_ctrl", ex_ctrl, 11'd0);
    model_reset();
    @(posedge clk); #1 rst = 1'b0;
    busy_seen = 0;
    run_cycle(6'h00, 6'd24, 5'd1, 5'd2, 1'b0);
    repeat (8) run_cycle(6'h00, 6'h20, 5'd1, 5'd2, 1'b0);
    check("mult_busy_cycles", busy_seen, MULT_LAT);

    repeat (3000) run_random();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
